bev_fb_arbiter: RTL and testbench
=================================

Name: bev_fb_arbiter

Overview:
- Owns the single-port BEV framebuffer RAM and schedules it between two clients:
  - the VGA scanout reader, which has absolute priority;
  - the BEV renderer writer, which is buffered and drained in idle cycles.
- Double-buffers the framebuffer with two banks and swaps front/back banks only at a frame boundary, so the display never shows a partially rendered frame.
- Sits between the VGA timing generator / pixel fetch logic and the framebuffer BRAM.

Parameters:
- ADDR_W, 15, word address width within one bank (160x120 = 19200 words).
- DATA_W, 8, pixel word width.
- FIFO_DEPTH, 4, renderer write FIFO entries; must be a power of two and at least 2.
- RD_LAT, 1, RAM read latency in cycles, from mem_en to mem_rdata; range 1..3.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse at pixel (0,0) from the VGA timing generator
- disp_req  in  1  scanout read request, single cycle
- disp_addr  in  ADDR_W  scanout word address
- disp_valid  out  1  disp_data is valid
- disp_data  out  DATA_W  read data, passed through from mem_rdata
- wr_valid  in  1  renderer write valid
- wr_ready  out  1  renderer write ready
- wr_addr  in  ADDR_W  renderer word address
- wr_data  in  DATA_W  renderer pixel
- wr_frame_done  in  1  pulse; renderer has finished the back-bank frame
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W+1  {bank, word address}
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- front_bank  out  1  bank currently being displayed
- swap_pending  out  1  frame finished, bank swap not yet done

Behaviour:
- Reset values:
  - front_bank=0; FIFO empty; state=RENDER.
  - disp_valid=0, swap_pending=0, mem_en=0, mem_we=0.
  - The read-valid pipeline is cleared, so reads in flight at reset never produce disp_valid.
- Write FIFO:
  - wr_ready = !fifo_full && state==RENDER.
  - An entry is pushed on wr_valid && wr_ready.
- Port arbitration (combinational, evaluated every cycle):
  - disp_req=1: mem_en=1, mem_we=0, mem_addr={front_bank, disp_addr}.
  - Else if the FIFO is not empty: mem_en=1, mem_we=1, mem_addr={~front_bank, head addr}, mem_wdata=head data; the head is popped the same cycle.
  - Else: mem_en=0, mem_we=0.
- Display reads are never stalled. disp_valid equals disp_req delayed RD_LAT cycles through a shift register; disp_data=mem_rdata.
- Push and pop in the same cycle are both allowed, including when the FIFO is full (a pop frees the slot). Occupancy is unchanged in that case.
- Write starvation: if disp_req is held high continuously, writes wait and the FIFO fills; wr_ready then drops. No write is ever lost.
- State machine:
  - RENDER: on wr_frame_done, go to DRAIN if the FIFO would be non-empty after this cycle, otherwise go to WAIT_SWAP.
  - DRAIN: when the FIFO becomes empty, go to WAIT_SWAP. frame_start is ignored in this state, so the swap defers to the next frame.
  - WAIT_SWAP: on frame_start, toggle front_bank and go to RENDER.
- swap_pending = (state != RENDER).
- A write accepted in the same cycle as wr_frame_done belongs to the finishing frame.
- wr_frame_done is ignored outside RENDER.
- front_bank changes only on the cycle after a frame_start pulse. A disp_req coincident with frame_start still reads the old front bank.

Optional Feature:
- Macro: BEV_FB_STATS_EN.
- Defined:
  - Adds output stall_count[15:0]: increments each cycle wr_valid && !wr_ready, saturates at 16'hFFFF.
  - Adds output late_swap_count[7:0]: increments each frame_start seen in DRAIN, saturates at 8'hFF.
  - Both counters clear on reset.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package bev_fb_pkg holds:
  - enum fb_arb_state_t {RENDER, DRAIN, WAIT_SWAP};
  - localparams FB_W=160, FB_H=120, FB_SCALE=4, FB_ADDR_W=15.
- One sub-module, bev_fb_wr_fifo:
  - synchronous FIFO holding {addr, data};
  - outputs full, empty and head;
  - supports push and pop in the same cycle.

Test Plan:
- Reset release, no requests -> mem_en=0, front_bank=0, wr_ready=1, disp_valid=0 throughout.
- disp_req with addr 0x0123, RD_LAT=1 -> same cycle mem_addr=0x0123 (bank 0), mem_we=0; next cycle disp_valid=1, disp_data=model RAM[0x0123].
- disp_req held high for 10 cycles while wr_valid is high continuously -> exactly 4 writes accepted, then wr_ready=0 and no RAM write occurs; after disp_req drops, 4 consecutive writes go to bank 1, then wr_ready=1.
- 3 writes queued under disp_req, then wr_frame_done, then frame_start while the FIFO is still non-empty -> no swap at that frame_start; FIFO drains; swap happens at the next frame_start (front_bank=1); stall/late counters match when BEV_FB_STATS_EN is defined.
- wr_frame_done with an empty FIFO -> swap_pending=1 and wr_ready=0 until frame_start; one cycle after frame_start, front_bank toggles and reads use the new bank.
- Assert reset while a read is in flight and the FIFO holds 2 entries -> no disp_valid pulse, FIFO empty, state RENDER, front_bank=0.

Source files
------------

// File: rtl/bev_fb_pkg.sv
// Shared types and framebuffer geometry for the BEV framebuffer arbiter.
package bev_fb_pkg;

  typedef enum logic [1:0] {
    RENDER    = 2'd0,
    DRAIN     = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_arb_state_t;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_SCALE  = 4;
  localparam int FB_ADDR_W = 15;

endpackage

// File: rtl/bev_fb_wr_fifo.sv
// Synchronous FIFO of renderer writes {addr, data}; push and pop may share a cycle,
// and a pop frees the slot for a push even when full.
module bev_fb_wr_fifo #(
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != (PW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

  assign full      = (cnt == (PW+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_addr = mem[rd_ptr][AW+DW-1:DW];
  assign head_data = mem[rd_ptr][DW-1:0];

endmodule

// File: rtl/bev_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win, renderer writes drain in idle cycles,
// front/back banks swap only at frame_start. Optional counters under BEV_FB_STATS_EN.
module bev_fb_arbiter
  import bev_fb_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              front_bank,
`ifdef BEV_FB_STATS_EN
  output logic [15:0]       stall_count,
  output logic [7:0]        late_swap_count,
`endif
  output logic              swap_pending
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fb_arb_state_t     state;
  logic              fifo_full, fifo_empty, push, pop, empty_next;
  logic [CW-1:0]     fifo_cnt;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [RD_LAT-1:0] vld_sr;

  assign wr_ready   = !fifo_full && (state == RENDER);
  assign push       = wr_valid && wr_ready;
  assign pop        = !disp_req && !fifo_empty;
  assign empty_next = ((fifo_cnt + CW'(push) - CW'(pop)) == '0);

  bev_fb_wr_fifo #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // Scanout owns the port outright; queued writes go to the back bank.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = head_data;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = {front_bank, disp_addr};
    end else if (!fifo_empty) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = {~front_bank, head_addr};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= disp_req;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  assign disp_valid = vld_sr[RD_LAT-1];
  assign disp_data  = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RENDER;
      front_bank <= 1'b0;
    end else begin
      case (state)
        RENDER:    if (wr_frame_done) state <= empty_next ? WAIT_SWAP : DRAIN;
        DRAIN:     if (empty_next) state <= WAIT_SWAP;
        WAIT_SWAP: if (frame_start) begin
                     front_bank <= ~front_bank;
                     state      <= RENDER;
                   end
        default:   state <= RENDER;
      endcase
    end
  end

  assign swap_pending = (state != RENDER);

`ifdef BEV_FB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count     <= '0;
      late_swap_count <= '0;
    end else begin
      if (wr_valid && !wr_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (frame_start && (state == DRAIN) && (late_swap_count != 8'hFF))
        late_swap_count <= late_swap_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bev_fb_arbiter.sv
// Directed bench for bev_fb_arbiter with a behavioural single-port RAM (RD_LAT=1).
module tb_bev_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, disp_req, wr_valid, wr_frame_done;
  logic [14:0] disp_addr, wr_addr;
  logic [7:0]  wr_data;
  logic        disp_valid, wr_ready, mem_en, mem_we, front_bank, swap_pending;
  logic [7:0]  disp_data, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
`ifdef BEV_FB_STATS_EN
  logic [15:0] stall_count;
  logic [7:0]  late_swap_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int nwr = 0;
  int acc, snap;

  bit [7:0] ram [65536];
  bit       written [65536];

  always #5 clk = ~clk;

  bev_fb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .disp_req      (disp_req),
    .disp_addr     (disp_addr),
    .disp_valid    (disp_valid),
    .disp_data     (disp_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_frame_done (wr_frame_done),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .front_bank    (front_bank),
`ifdef BEV_FB_STATS_EN
    .stall_count     (stall_count),
    .late_swap_count (late_swap_count),
`endif
    .swap_pending  (swap_pending)
  );

  // Unwritten locations read back as addr[7:0] ^ 8'h5A.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
        nwr <= nwr + 1;
      end else begin
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : (mem_addr[7:0] ^ 8'h5A);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; frame_start = 0; disp_req = 0; wr_valid = 0; wr_frame_done = 0;
    disp_addr = '0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_mem_en", mem_en, 0);
      chk("idle_front", front_bank, 0);
      chk("idle_wr_ready", wr_ready, 1);
      chk("idle_disp_valid", disp_valid, 0);
      chk("idle_swap_pending", swap_pending, 0);
      tick();
    end

    // Single scanout read
    disp_req = 1; disp_addr = 15'h0123; #1;
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 16'h0123);
    tick();
    disp_req = 0; #1;
    chk("rd_disp_valid", disp_valid, 1);
    chk("rd_disp_data", disp_data, 8'h79);
    tick(); #1;
    chk("rd_valid_drop", disp_valid, 0);

    // Write starvation under continuous scanout
    acc = 0; snap = nwr;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1; wr_valid = 1;
      wr_addr = 15'h100 + 15'(acc); wr_data = 8'hA0 + 8'(acc); #1;
      if (wr_ready) acc++;
      tick();
    end
    #1;
    chk("starve_accepted", acc, 4);
    chk("starve_wr_ready", wr_ready, 0);
    chk("starve_no_ram_wr", nwr, snap);
    disp_req = 0; wr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_we", mem_we, 1);
      chk("drain_addr", mem_addr, 16'h8100 + 16'(i));
      chk("drain_data", mem_wdata, 8'hA0 + 8'(i));
      tick();
    end
    #1;
    chk("drain_ram_wr", nwr, snap + 4);
    chk("drain_idle", mem_en, 0);
    chk("drain_wr_ready", wr_ready, 1);

    // Late swap: frame_start arrives while still draining
    for (int i = 0; i < 3; i++) begin
      disp_req = 1; wr_valid = 1; wr_addr = 15'h200 + 15'(i); wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_valid = 0; wr_frame_done = 1;
    tick();
    wr_frame_done = 0; #1;
    chk("late_pending", swap_pending, 1);
    chk("late_wr_ready", wr_ready, 0);
    frame_start = 1;
    tick();
    frame_start = 0; #1;
    chk("late_no_swap", front_bank, 0);
    chk("late_still_pending", swap_pending, 1);
    disp_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_drain_addr", mem_addr, 16'h8200 + 16'(i));
      tick();
    end
    #1;
    chk("late_wait_idle", mem_en, 0);
    chk("late_wait_pending", swap_pending, 1);
    frame_start = 1; disp_req = 1; disp_addr = 15'h0123; #1;
    chk("swap_old_bank_rd", mem_addr, 16'h0123);
    tick();
    frame_start = 0; disp_addr = 15'h0200; #1;
    chk("swap_front", front_bank, 1);
    chk("swap_new_bank_rd", mem_addr, 16'h8200);
    chk("swap_prev_data", disp_data, 8'h79);
    tick();
    disp_req = 0; #1;
    chk("swap_written_data", disp_data, 8'hC0);
    chk("swap_cleared", swap_pending, 0);
    chk("swap_wr_ready", wr_ready, 1);
`ifdef BEV_FB_STATS_EN
    chk("stall_count", stall_count, 6);
    chk("late_swap_count", late_swap_count, 1);
`endif

    // Frame done with empty FIFO
    wr_frame_done = 1;
    tick();
    wr_frame_done = 0; #1;
    chk("empty_done_pending", swap_pending, 1);
    chk("empty_done_wr_ready", wr_ready, 0);
    tick(); tick(); #1;
    chk("empty_done_hold", swap_pending, 1);
    frame_start = 1; disp_req = 1; disp_addr = 15'h0300; #1;
    chk("empty_done_old_bank", mem_addr, 16'h8300);
    tick();
    frame_start = 0; disp_addr = 15'h0123; #1;
    chk("empty_done_front", front_bank, 0);
    chk("empty_done_new_bank", mem_addr, 16'h0123);
    tick();
    disp_req = 0; #1;
    chk("empty_done_valid", disp_valid, 1);
    chk("empty_done_data", disp_data, 8'h79);

    // Get front_bank=1 so reset has something to clear
    wr_frame_done = 1; tick(); wr_frame_done = 0;
    frame_start = 1;   tick(); frame_start = 0; #1;
    chk("pre_reset_front", front_bank, 1);

    // Reset with a read in flight and two queued writes
    for (int i = 0; i < 2; i++) begin
      disp_req = 1; wr_valid = 1; wr_addr = 15'h400 + 15'(i); wr_data = 8'h11;
      tick();
    end
    wr_valid = 0; #1;
    reset = 1;
    tick();
    disp_req = 0; snap = nwr; #1;
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_front", front_bank, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_fifo_empty", mem_en, 0);
    chk("rst_wr_ready", wr_ready, 1);
    reset = 0;
    tick(); #1;
    chk("post_rst_valid", disp_valid, 0);
    chk("post_rst_idle", mem_en, 0);
    tick(); #1;
    chk("post_rst_no_wr", nwr, snap);
`ifdef BEV_FB_STATS_EN
    chk("rst_stall_count", stall_count, 0);
    chk("rst_late_count", late_swap_count, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
